// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand (plus sbox byte-substitution helper)
// Brief    : Iterative AES-128 key schedule streaming round keys 0..10 over a
//            valid/ready handshake; SubWord built from four sbox instances.
// Revision : 1.0 - initial release
// ============================================================================

// ============================================================================
// Module   : sbox
// Brief    : Combinational AES forward S-box, table lookup.
// Revision : 1.0 - initial release
// ============================================================================
module sbox (
   input  logic [7:0] x,
   output logic [7:0] y
);

   // Entry 0 sits in the most significant byte, so entry x starts at bit 8*(255-x).
   localparam logic [2047:0] C_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] w_sel;

   assign w_sel = {~x, 3'b000};
   assign y     = C_SBOX[w_sel +: 8];

endmodule

module aes_key_expand #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic         rk_valid,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         busy,
   output logic         done
);

   localparam logic [3:0] C_LAST_IDX = 4'(NUM_ROUNDS);
   localparam logic [7:0] C_RCON_1   = 8'h01;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_EXPAND = 1'b1
   } state_t;

   state_t       r_state, w_state_nxt;
   logic [127:0] r_key,   w_key_nxt;
   logic [3:0]   r_idx,   w_idx_nxt;
   logic         r_valid, w_valid_nxt;
   logic         r_done,  w_done_nxt;
   logic [7:0]   r_rcon,  w_rcon_nxt;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3;
   logic [31:0]  w_rot, w_sub, w_temp;
   logic [31:0]  w_n0, w_n1, w_n2, w_n3;
   logic [127:0] w_key_next_round;
   logic [7:0]   w_rcon_adv;
   logic         w_xfer;

   assign w_w0 = r_key[127:96];
   assign w_w1 = r_key[95:64];
   assign w_w2 = r_key[63:32];
   assign w_w3 = r_key[31:0];

   assign w_rot = {w_w3[23:0], w_w3[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_subword
         sbox u_sbox (
            .x (w_rot[8*gi +: 8]),
            .y (w_sub[8*gi +: 8])
         );
      end
   endgenerate

   assign w_temp = w_sub ^ {r_rcon, 24'h000000};
   assign w_n0   = w_w0 ^ w_temp;
   assign w_n1   = w_n0 ^ w_w1;
   assign w_n2   = w_n1 ^ w_w2;
   assign w_n3   = w_n2 ^ w_w3;
   assign w_key_next_round = {w_n0, w_n1, w_n2, w_n3};

   // xtime in GF(2^8): doubling with reduction by the AES polynomial
   assign w_rcon_adv = r_rcon[7] ? ({r_rcon[6:0], 1'b0} ^ 8'h1b) : {r_rcon[6:0], 1'b0};

   assign w_xfer = r_valid & rk_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_key   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_rcon  <= C_RCON_1;
      end else begin
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
         r_idx   <= w_idx_nxt;
         r_valid <= w_valid_nxt;
         r_done  <= w_done_nxt;
         r_rcon  <= w_rcon_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_idx_nxt   = r_idx;
      w_valid_nxt = r_valid;
      w_done_nxt  = 1'b0;
      w_rcon_nxt  = r_rcon;
      case (r_state)
         S_IDLE: begin
            w_valid_nxt = 1'b0;
            if (start) begin
               w_state_nxt = S_EXPAND;
               w_key_nxt   = key_in;
               w_idx_nxt   = 4'd0;
               w_valid_nxt = 1'b1;
               w_rcon_nxt  = C_RCON_1;
            end
         end
         S_EXPAND: begin
            if (w_xfer) begin
               if (r_idx == C_LAST_IDX) begin
                  // Final key handed over: keep key/index visible, drop valid
                  w_state_nxt = S_IDLE;
                  w_valid_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_key_nxt   = w_key_next_round;
                  w_idx_nxt   = r_idx + 4'd1;
                  w_rcon_nxt  = w_rcon_adv;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   assign rk_valid  = r_valid;
   assign round_key = r_key;
   assign round_idx = r_idx;
   assign busy      = (r_state == S_EXPAND);
   assign done      = r_done;

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key schedule. It produces round keys 0..10, one per accepted handshake, for the round datapath. It computes SubWord with four instances of the existing combinational sbox byte-substitution module. It sits upstream of the AddRoundKey stage and streams keys in order, so no 176-byte key store is needed.

Parameters:
NUM_ROUNDS, 10, index of the last round key produced; only 10 (AES-128) is supported, and other values are illegal.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request expansion of key_in; sampled only in IDLE
key_in  input  128  cipher key; byte 0 = key_in[127:120]; sampled on the accepted start cycle only
rk_ready  input  1  downstream accepts round_key this cycle
rk_valid  output  1  round_key/round_idx valid
round_key  output  128  current round key, same byte order as key_in
round_idx  output  4  index of round_key, 0..10
busy  output  1  high in EXPAND state
done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-expansion):
  - state=IDLE; rk_valid=0, round_key=0, round_idx=0, busy=0, done=0; rcon register=8'h01.
  - The expansion is abandoned; no partial output follows reset release.
- State machine has two states, IDLE and EXPAND.
  - IDLE with start=1: accept. At the next edge, round_key=key_in, round_idx=0, rk_valid=1, busy=1, rcon=8'h01, state=EXPAND. Latency is 1 cycle.
  - IDLE with start=0: hold all outputs; rk_valid=0.
  - EXPAND: start is ignored, with no queuing.
- Handshake:
  - A transfer occurs on a cycle with rk_valid=1 and rk_ready=1.
  - While rk_valid=1 and rk_ready=0, round_key and round_idx hold stable. There is no combinational path from rk_ready to any output.
  - Transfer with round_idx<10: at the next edge, round_key=next key, round_idx+1, rk_valid stays 1, and rcon advances.
  - With rk_ready held high, keys 0..10 stream on 11 consecutive cycles.
  - Transfer with round_idx=10: at the next edge, rk_valid=0, busy=0, done=1 for exactly one cycle, state=IDLE. round_key and round_idx retain their last values.
  - start asserted in the done cycle is accepted, because the state is IDLE.
- Next-key arithmetic: current key words are w0..w3, with w0=round_key[127:96].
  - RotWord(w3) = {w3[23:0], w3[31:24]}.
  - temp = SubWord(RotWord(w3)) XOR {rcon, 24'h0}, where SubWord applies sbox to each byte.
  - n0=w0^temp, n1=n0^w1, n2=n1^w2, n3=n2^w3. Next round_key = {n0,n1,n2,n3}.
  - The sbox path is combinational from the round_key register to the next-key register; the timing budget is one clock.
- rcon sequence by produced index 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - Update rule: rcon = rcon[7] ? (rcon<<1)^8'h1b : rcon<<1, truncated to 8 bits.
  - rcon is reloaded to 01 on every accepted start.
- Boundaries:
  - round_idx never exceeds 10 and never wraps.
  - rk_ready=1 while rk_valid=0 has no effect.
  - start and rk_ready both high in IDLE: start wins.
  - key_in changes after the accepted start do not affect the expansion.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1:
   - idx0 = the key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Keys arrive on 11 consecutive cycles, then done pulses once.
2. All-zero key:
   - idx1 = 62636363626363636263636362636363; idx2 = 9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
   - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. Backpressure, FIPS-197 key:
   - rk_ready toggles randomly, including a 5-cycle low at idx 3 (round_key 3d80477d4716fe3e1e237e446d7a883b must hold stable).
   - The key sequence is identical to scenario 1, and rk_valid never drops before idx 10 is accepted.
4. start pulsed during EXPAND with a different key_in:
   - Ignored; the sequence is unchanged.
   - start in the done cycle begins a new expansion; idx0 appears on the next cycle.
5. rst_n asserted asynchronously while round_idx=6:
   - All outputs go to 0 immediately.
   - After release, no rk_valid appears until start; a fresh start yields the correct idx1.
6. start with the all-ones key ffff…ff:
   - idx1 = e8e9e9e917161616e8e9e9e917161616, confirming rcon 01 is applied to byte 0 only.
